// File: rtl/address_reader_pkg.sv
// Shared definitions for the address reader: default widths and the
// 2-bit state encoding used by the burst controller.
package address_reader_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage

// File: rtl/address_reader.sv
// Strided burst reader: issues one memory read at a time, parks each returned
// word on a valid/ready output, and pulses done when the burst has drained.
module address_reader
  import address_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [LEN_W-1:0]  length,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] stride_q;
  logic [LEN_W-1:0]  count;

  // The strobe is decoded straight from the state, so it can only ever be a
  // single cycle long and only one read can be in flight.
  assign mem_rd_en = (state == ST_ISSUE);
  assign mem_addr  = cur_addr;
  assign busy      = (state != ST_IDLE);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cur_addr  <= '0;
      stride_q  <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (length != '0) begin
              cur_addr <= base_addr;
              stride_q <= stride;
              count    <= length;
              state    <= ST_ISSUE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (mem_rd_valid) begin
            out_data  <= mem_rd_data;
            out_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (count == LEN_W'(1)) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              count    <= count - LEN_W'(1);
              // Wraps modulo 2^ADDR_W by construction.
              cur_addr <= cur_addr + stride_q;
              state    <= ST_ISSUE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_address_reader.sv
// Self-checking bench for address_reader: a latency-configurable memory model,
// an output monitor, and a burst-level reference model (address sequence/data).
module tb_address_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] stride;
  logic [7:0]  length;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic        mem_rd_valid;
  logic [15:0] mem_rd_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;
  int ready_mode = 0;          // 0: always ready, 1: random, 2: manual_ready
  logic manual_ready = 1'b1;
  logic [15:0] key;

  logic [15:0] addr_q[$];
  int          rd_cyc_q[$];
  logic [15:0] data_q[$];
  int          xfer_cyc_q[$];
  int          ov_cyc_q[$];
  int          done_cyc_q[$];
  int          busy_cnt = 0;

  address_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .stride(stride), .length(length), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rd_valid(mem_rd_valid),
    .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ key;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory model: answers each strobe mem_lat cycles later.
  initial begin
    logic [15:0] a;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (mem_rd_en === 1'b1) begin
        a = mem_addr;
        @(posedge clk);
        repeat (mem_lat - 1) @(posedge clk);
        #1;
        mem_rd_valid = 1'b1;
        mem_rd_data  = mem_word(a);
        @(posedge clk);
        #1;
        mem_rd_valid = 1'b0;
        mem_rd_data  = 16'($urandom);
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0)      out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
      else                      out_ready = manual_ready;
    end
  end

  // Monitor: sampled mid-cycle, records everything the checks need.
  initial begin
    logic prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd_en === 1'b1) begin
        addr_q.push_back(mem_addr);
        rd_cyc_q.push_back(cyc);
      end
      if (out_valid === 1'b1 && prev_ov !== 1'b1) ov_cyc_q.push_back(cyc);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        data_q.push_back(out_data);
        xfer_cyc_q.push_back(cyc);
      end
      if (done === 1'b1) done_cyc_q.push_back(cyc);
      if (busy === 1'b1) busy_cnt++;
      prev_ov = out_valid;
    end
  end

  task automatic start_burst(input logic [15:0] b, input logic [15:0] s,
                             input logic [7:0] n, output int sc);
    @(posedge clk);
    #1;
    base_addr = b;
    stride    = s;
    length    = n;
    start     = 1'b1;
    sc        = cyc;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = 16'($urandom);
    stride    = 16'($urandom);
    length    = 8'($urandom);
  endtask

  task automatic wait_done(input int budget, input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cyc_q.size() > d0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(posedge clk);
  endtask

  // Burst-level reference: address i is base + i*stride mod 2^16, data is the
  // memory word at that address, exactly one done right after the last transfer.
  task automatic check_burst(input string name, input logic [15:0] b,
                             input logic [15:0] s, input int n, input int lat,
                             input int a0, input int x0, input int d0,
                             input int o0, input int sc, input bit ok);
    logic [15:0] exp_a;
    int nr, nx, nd;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout: done not seen within budget", name);
    end
    nr = addr_q.size() - a0;
    nx = data_q.size() - x0;
    nd = done_cyc_q.size() - d0;
    checks++;
    if (nr != n) begin
      errors++;
      $display("FAIL %s rd_count: got %0d expected %0d", name, nr, n);
    end
    checks++;
    if (nx != n) begin
      errors++;
      $display("FAIL %s xfer_count: got %0d expected %0d", name, nx, n);
    end
    exp_a = b;
    for (int i = 0; i < n; i++) begin
      if (i < nr) begin
        checks++;
        if (addr_q[a0+i] !== exp_a) begin
          errors++;
          $display("FAIL %s addr[%0d]: got %h expected %h", name, i, addr_q[a0+i], exp_a);
        end
      end
      if (i < nx) begin
        checks++;
        if (data_q[x0+i] !== mem_word(exp_a)) begin
          errors++;
          $display("FAIL %s data[%0d]: got %h expected %h", name, i, data_q[x0+i], mem_word(exp_a));
        end
      end
      if (i > 0 && i < nr) begin
        checks++;
        if (rd_cyc_q[a0+i] - rd_cyc_q[a0+i-1] < lat + 2) begin
          errors++;
          $display("FAIL %s rd_spacing[%0d]: got %0d expected >= %0d", name, i,
                   rd_cyc_q[a0+i] - rd_cyc_q[a0+i-1], lat + 2);
        end
      end
      exp_a = exp_a + s;
    end
    if (nr > 0) begin
      checks++;
      if (rd_cyc_q[a0] != sc + 1) begin
        errors++;
        $display("FAIL %s rd_latency: got cycle %0d expected %0d", name, rd_cyc_q[a0], sc + 1);
      end
      checks++;
      if (ov_cyc_q.size() <= o0 || ov_cyc_q[o0] != rd_cyc_q[a0] + lat + 1) begin
        errors++;
        $display("FAIL %s out_valid_latency: got %0d expected %0d", name,
                 (ov_cyc_q.size() > o0) ? ov_cyc_q[o0] : -1, rd_cyc_q[a0] + lat + 1);
      end
    end
    checks++;
    if (nd != 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d expected 1", name, nd);
    end else if (nx > 0) begin
      checks++;
      if (done_cyc_q[d0] != xfer_cyc_q[$] + 1) begin
        errors++;
        $display("FAIL %s done_timing: got %0d expected %0d", name, done_cyc_q[d0], xfer_cyc_q[$] + 1);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after: got %b expected 0", name, busy);
    end
  endtask

  task automatic run_burst(input string name, input logic [15:0] b,
                           input logic [15:0] s, input logic [7:0] n, input int lat);
    int a0, x0, d0, o0, sc;
    bit ok;
    mem_lat = lat;
    a0 = addr_q.size(); x0 = data_q.size(); d0 = done_cyc_q.size(); o0 = ov_cyc_q.size();
    start_burst(b, s, n, sc);
    wait_done(600, d0, ok);
    check_burst(name, b, s, int'(n), lat, a0, x0, d0, o0, sc, ok);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #2;
    checks++;
    if ({mem_rd_en, mem_addr, out_valid, out_data, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b addr=%h ov=%b data=%h busy=%b done=%b expected all 0",
               mem_rd_en, mem_addr, out_valid, out_data, busy, done);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_rd_en, busy, done, out_valid} !== 4'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got en=%b busy=%b done=%b ov=%b expected 0",
               mem_rd_en, busy, done, out_valid);
    end
  endtask

  task automatic test_basic;
    ready_mode = 0;
    run_burst("basic", 16'h0010, 16'h0001, 8'd3, 1);
  endtask

  task automatic test_backpressure;
    int a0, x0, d0, o0, sc, n_rd;
    bit ok, seen;
    logic [15:0] held;
    mem_lat = 1;
    ready_mode = 2;
    manual_ready = 1'b0;
    a0 = addr_q.size(); x0 = data_q.size(); d0 = done_cyc_q.size(); o0 = ov_cyc_q.size();
    start_burst(16'h0200, 16'h0004, 8'd2, sc);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (out_valid === 1'b1);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL backpressure_valid: out_valid not seen, expected 1");
    end
    held = out_data;
    n_rd = addr_q.size();
    checks++;
    if (held !== mem_word(16'h0200)) begin
      errors++;
      $display("FAIL backpressure_word: got %h expected %h", held, mem_word(16'h0200));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== held) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got ov=%b data=%h expected ov=1 data=%h",
                 i, out_valid, out_data, held);
      end
    end
    checks++;
    if (addr_q.size() != n_rd) begin
      errors++;
      $display("FAIL backpressure_no_read: got %0d reads expected %0d", addr_q.size(), n_rd);
    end
    manual_ready = 1'b1;
    wait_done(200, d0, ok);
    check_burst("backpressure", 16'h0200, 16'h0004, 2, 1, a0, x0, d0, o0, sc, ok);
    ready_mode = 0;
  endtask

  task automatic test_wrap;
    ready_mode = 0;
    run_burst("wrap", 16'hFFFE, 16'h0002, 8'd2, 1);
  endtask

  task automatic test_zero_length;
    int a0, d0, b0, sc;
    a0 = addr_q.size(); d0 = done_cyc_q.size(); b0 = busy_cnt;
    start_burst(16'h1234, 16'h0001, 8'd0, sc);
    repeat (6) @(posedge clk);
    checks++;
    if (done_cyc_q.size() - d0 != 1) begin
      errors++;
      $display("FAIL zero_done_count: got %0d expected 1", done_cyc_q.size() - d0);
    end else begin
      checks++;
      if (done_cyc_q[d0] != sc + 1) begin
        errors++;
        $display("FAIL zero_done_timing: got %0d expected %0d", done_cyc_q[d0], sc + 1);
      end
    end
    checks++;
    if (addr_q.size() != a0) begin
      errors++;
      $display("FAIL zero_no_read: got %0d reads expected 0", addr_q.size() - a0);
    end
    checks++;
    if (busy_cnt != b0) begin
      errors++;
      $display("FAIL zero_busy: got %0d busy cycles expected 0", busy_cnt - b0);
    end
  endtask

  task automatic test_latency_restart;
    int a0, x0, d0, o0, sc;
    bit ok;
    ready_mode = 0;
    mem_lat = 4;
    a0 = addr_q.size(); x0 = data_q.size(); d0 = done_cyc_q.size(); o0 = ov_cyc_q.size();
    start_burst(16'h0400, 16'h0010, 8'd3, sc);
    repeat (2) @(posedge clk);
    #1;
    base_addr = 16'h5000;
    stride    = 16'h0001;
    length    = 8'd1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(300, d0, ok);
    check_burst("latency_restart", 16'h0400, 16'h0010, 3, 4, a0, x0, d0, o0, sc, ok);
  endtask

  task automatic test_random;
    logic [15:0] b, s;
    logic [7:0]  n;
    int lat;
    ready_mode = 1;
    for (int k = 0; k < 6; k++) begin
      b   = 16'($urandom);
      s   = 16'($urandom);
      n   = 8'($urandom_range(1, 6));
      lat = $urandom_range(1, 4);
      run_burst($sformatf("random%0d", k), b, s, n, lat);
    end
    ready_mode = 0;
  endtask

  task automatic test_reset_mid;
    int a0, d0, b0, sc;
    bit seen, ov_seen;
    ready_mode = 0;
    mem_lat = 3;
    a0 = addr_q.size(); d0 = done_cyc_q.size();
    start_burst(16'h0300, 16'h0001, 8'd2, sc);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      seen = (addr_q.size() > a0);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_mid_issue: no read strobe seen, expected one");
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_rd_en, mem_addr, out_valid, out_data, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got en=%b addr=%h ov=%b data=%h busy=%b done=%b expected all 0",
               mem_rd_en, mem_addr, out_valid, out_data, busy, done);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    b0 = busy_cnt;
    ov_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ov_seen = 1'b1;
    end
    checks++;
    if (ov_seen) begin
      errors++;
      $display("FAIL reset_mid_stray: got out_valid=1 expected 0");
    end
    checks++;
    if (done_cyc_q.size() != d0) begin
      errors++;
      $display("FAIL reset_mid_done: got %0d done pulses expected 0", done_cyc_q.size() - d0);
    end
    checks++;
    if (busy_cnt != b0 || out_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_idle: got busy_cycles=%0d data=%h expected 0 and 0000",
               busy_cnt - b0, out_data);
    end
  endtask

  initial begin
    key       = 16'($urandom);
    start     = 1'b0;
    base_addr = '0;
    stride    = '0;
    length    = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_length();
    test_latency_restart();
    test_random();
    test_reset_mid();
    run_burst("after_reset", 16'h0700, 16'h0003, 8'd2, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/address_reader.md
ADDRESS_READER -- requirements
Module: address_reader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the data width.
REQ-003 The block SHALL have parameter LEN_W, default 8, meaning the burst-length counter width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 start  input  1  SHALL request a read burst, sampled only in IDLE.
REQ-007 base_addr  input  ADDR_W  SHALL be the first address, latched when start is accepted.
REQ-008 stride  input  ADDR_W  SHALL be the address increment, latched when start is accepted.
REQ-009 length  input  LEN_W  SHALL be the number of words to read, latched when start is accepted.
REQ-010 mem_rd_en  output  1  SHALL be a one-cycle read strobe to memory.
REQ-011 mem_addr  output  ADDR_W  SHALL be the read address, valid while mem_rd_en=1.
REQ-012 mem_rd_valid  input  1  SHALL indicate that mem_rd_data is valid (any latency ≥1 cycle).
REQ-013 mem_rd_data  input  DATA_W  SHALL be the returned read data.
REQ-014 out_valid  output  1  SHALL indicate that out_data holds a word.
REQ-015 out_data  output  DATA_W  SHALL be the word delivered to the consumer.
REQ-016 out_ready  input  1  SHALL be consumer acceptance; a transfer occurs when out_valid=1 and out_ready=1 at a rising edge.
REQ-017 busy  output  1  SHALL be 1 in every state except IDLE.
REQ-018 done  output  1  SHALL be a one-cycle pulse at burst completion.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT and HOLD.
REQ-020 In IDLE with start=1 and length≠0, the block SHALL latch base_addr, stride and length into cur_addr, stride_q and count, then go to ISSUE.
REQ-021 In IDLE with start=1 and length=0, the block SHALL pulse done for one cycle, issue no read, and stay in IDLE.
REQ-022 In ISSUE, the block SHALL assert mem_rd_en=1 with mem_addr=cur_addr for exactly one cycle, then go to WAIT.
REQ-023 In WAIT, when mem_rd_valid=1 the block SHALL register mem_rd_data into out_data, set out_valid=1, and go to HOLD.
REQ-024 In HOLD, on a transfer the block SHALL clear out_valid; if count=1 it SHALL pulse done and go to IDLE, otherwise it SHALL decrement count, set cur_addr=cur_addr+stride_q, and go to ISSUE.
REQ-025 In HOLD with out_ready=0, the block SHALL hold out_data and out_valid stable indefinitely.
REQ-026 At most one read SHALL be outstanding at any time; mem_rd_en SHALL never be asserted outside ISSUE.
REQ-027 The block SHALL ignore mem_rd_valid in IDLE, ISSUE and HOLD.
REQ-028 The block SHALL ignore start whenever busy=1.
REQ-029 Address arithmetic SHALL wrap modulo 2^ADDR_W with no overflow flag.
REQ-030 Latency, with 1-cycle memory: mem_rd_en SHALL be high in the cycle after start is accepted, and out_valid SHALL be high in the cycle after mem_rd_valid is sampled.
REQ-031 done SHALL be high in the cycle immediately after the final transfer edge.
REQ-032 A burst of N words SHALL produce exactly N mem_rd_en pulses and N transfers.

Reset
REQ-033 rst=0 SHALL immediately force: state=IDLE, mem_rd_en=0, mem_addr=0, out_valid=0, out_data=0, busy=0, done=0, count=0, cur_addr=0.
REQ-034 Reset asserted mid-burst SHALL abandon the burst without a done pulse; a later mem_rd_valid SHALL be ignored.

Structure
REQ-035 The state encoding (2-bit IDLE/ISSUE/WAIT/HOLD) and the default widths SHALL reside in the shared processor package.
REQ-036 The block SHALL be a single module with no sub-modules; the count and address registers SHALL be inline.

Verification
REQ-037 Basic burst: base=0x0010, stride=1, length=3, 1-cycle memory, out_ready=1 -> mem_addr 0x0010, 0x0011, 0x0012; three transfers; done one cycle after the third.
REQ-038 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_data stable, no new mem_rd_en; resume on out_ready=1.
REQ-039 Wrap: base=0xFFFE, stride=2, length=2 -> mem_addr 0xFFFE, then 0x0000.
REQ-040 Zero length: start with length=0 -> done pulse for 1 cycle, no mem_rd_en, busy stays 0.
REQ-041 Variable latency plus restart attempt: mem_rd_valid after 4 cycles; start pulsed while busy -> start ignored; burst completes normally.
REQ-042 Reset mid-burst: rst=0 in WAIT, then a stray mem_rd_valid -> all outputs 0, no done pulse, out_valid stays 0.
